// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed byte stream into 32-bit little-endian words
// and writes them into instruction memory from word 0, holding the CPU in reset meanwhile.
`timescale 1ns/1ps
module imem_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [1:0]       byte_idx;

  logic             accept_c;
  logic [LEN_W-1:0] len_full_c;
  logic [LEN_W-1:0] next_count_c;

  // Handshake and helper values derived from current registers
  assign accept_c     = in_valid & in_ready;
  assign len_full_c   = {in_byte, len[7:0]};
  assign next_count_c = LEN_W'(words_loaded) + LEN_W'(1);

  // Session FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      byte_idx     <= '0;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            wr_addr      <= '0;
            byte_idx     <= '0;
            len          <= '0;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
          end
        end

        LEN_LO: begin
          if (accept_c) begin
            len[7:0] <= in_byte;
            state    <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (accept_c) begin
            len <= len_full_c;
            if (len_full_c == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
            end else if (len_full_c > LEN_W'(DEPTH)) begin
              state    <= ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept_c) begin
            wr_data[{byte_idx, 3'b000} +: 8] <= in_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state    <= WRITE;
              wr_en    <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end

        WRITE: begin
          wr_en        <= 1'b0;
          wr_addr      <= wr_addr + ADDR_W'(1);
          words_loaded <= words_loaded + (ADDR_W + 1)'(1);
          byte_idx     <= '0;
          if (next_count_c == len) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          wr_en    <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized sessions against a byte-to-word reference model with a
// write scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] data_q[$];
  int         total = 0;
  int         bad = 0;
  int         writes_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      wr_t e;
      writes_seen++;
      check("in_ready_during_write", 64'(in_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", 64'(wr_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference model: N words of little-endian packed bytes at addresses 0..N-1,
  // limited to the complete words actually supplied; nothing for N==0 or N>DEPTH.
  task automatic push_expected(input int n);
    int nw;
    wr_t e;
    if (n > 0 && n <= int'(DEPTH)) begin
      nw = data_q.size() / 4;
      if (n < nw) nw = n;
      for (int w = 0; w < nw; w++) begin
        e.addr = ADDR_W'(w);
        e.data = DATA_W'(data_q[4*w]) + (DATA_W'(data_q[4*w+1]) << 8) +
                 (DATA_W'(data_q[4*w+2]) << 16) + (DATA_W'(data_q[4*w+3]) << 24);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    logic rdy;
    int   budget;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    in_byte  = b;
    rdy      = 1'b0;
    budget   = 20;
    while (!rdy && budget > 0) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!rdy) check("send_timeout", 64'(rdy), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_data(input int from, input int upto, input bit gaps);
    for (int i = from; i < upto; i++) send_byte(data_q[i], gaps);
  endtask

  task automatic wait_end();
    int budget = 30;
    while (!(done || error) && budget > 0) begin
      tick();
      budget--;
    end
    if (!(done || error)) check("end_timeout", 64'(done | error), 64'd1);
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    tick();

    // 1: two fixed words
    data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    pulse_start();
    check("t1_cpu_hold_active", 64'(cpu_hold), 64'd1);
    push_expected(2);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_data(0, 8, 1'b0);
    wait_end();
    check("t1_done", 64'(done), 64'd1);
    check("t1_words", 64'(words_loaded), 64'd2);
    check("t1_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t1_drain", 64'(exp_q.size()), 64'd0);

    // 2: zero length
    w0 = writes_seen;
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check("t2_done", 64'(done), 64'd1);
    check("t2_words", 64'(words_loaded), 64'd0);
    check("t2_no_writes", 64'(writes_seen - w0), 64'd0);

    // 3: length too large
    pulse_start();
    send_byte(8'h41, 1'b0); send_byte(8'h00, 1'b0);
    wait_end();
    tick();
    check("t3_error", 64'(error), 64'd1);
    check("t3_done", 64'(done), 64'd0);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t3_no_writes", 64'(writes_seen - w0), 64'd0);

    // 4: full memory with random gaps
    fill_random(256);
    w0 = writes_seen;
    pulse_start();
    check("t4_error_cleared", 64'(error), 64'd0);
    push_expected(64);
    send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    send_data(0, 256, 1'b1);
    wait_end();
    check("t4_done", 64'(done), 64'd1);
    check("t4_words", 64'(words_loaded), 64'd64);
    check("t4_writes", 64'(writes_seen - w0), 64'd64);
    check("t4_drain", 64'(exp_q.size()), 64'd0);

    // 5: async reset in the middle of word 1
    fill_random(6);
    pulse_start();
    push_expected(2);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_data(0, 6, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("t5_in_ready", 64'(in_ready), 64'd0);
    check("t5_wr_en", 64'(wr_en), 64'd0);
    check("t5_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t5_words", 64'(words_loaded), 64'd0);
    check("t5_wr_addr", 64'(wr_addr), 64'd0);
    check("t5_drain", 64'(exp_q.size()), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    fill_random(12);
    pulse_start();
    push_expected(3);
    send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
    send_data(0, 12, 1'b1);
    wait_end();
    check("t5b_done", 64'(done), 64'd1);
    check("t5b_words", 64'(words_loaded), 64'd3);

    // 6: start ignored mid-DATA, honoured in DONE
    fill_random(8);
    pulse_start();
    push_expected(2);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_data(0, 2, 1'b0);
    pulse_start();
    check("t6_hold_kept", 64'(cpu_hold), 64'd1);
    check("t6_ready_kept", 64'(in_ready), 64'd1);
    check("t6_words_kept", 64'(words_loaded), 64'd0);
    send_data(2, 8, 1'b0);
    wait_end();
    check("t6_done", 64'(done), 64'd1);
    check("t6_words", 64'(words_loaded), 64'd2);
    fill_random(4);
    pulse_start();
    check("t6_done_cleared", 64'(done), 64'd0);
    check("t6_restart_hold", 64'(cpu_hold), 64'd1);
    check("t6_restart_addr", 64'(wr_addr), 64'd0);
    push_expected(1);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_data(0, 4, 1'b0);
    wait_end();
    check("t6b_words", 64'(words_loaded), 64'd1);
    repeat (3) tick();
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so a stuck DUT still terminates
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
